// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, pipeline register layouts and decode helpers for the 5-stage cpu
package cpu_pkg;
   localparam int DIV_DEFAULT = 34;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [5:0] OP_R = 6'h00, OP_MUL = 6'h1C, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A, FN_MUL = 6'h02;
   typedef enum logic [3:0] {A_NOP, A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_MUL, A_ADDI, A_LW, A_SW} alu_op_t;
   typedef struct packed {
      alu_op_t     op;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
   } id_ex_t;
   typedef struct packed {
      alu_op_t     op;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
      logic [31:0] store;
   } ex_mem_t;
   typedef struct packed {
      logic        we;
      logic [4:0]  dest;
      logic [31:0] val;
   } mem_wb_t;
   // anything not recognised collapses to A_NOP so it never writes state
   function automatic alu_op_t decode(input logic [31:0] ins);
      return (ins[31:26] == OP_R   && ins[5:0] == FN_ADD) ? A_ADD :
             (ins[31:26] == OP_R   && ins[5:0] == FN_SUB) ? A_SUB :
             (ins[31:26] == OP_R   && ins[5:0] == FN_AND) ? A_AND :
             (ins[31:26] == OP_R   && ins[5:0] == FN_OR ) ? A_OR  :
             (ins[31:26] == OP_R   && ins[5:0] == FN_SLT) ? A_SLT :
             (ins[31:26] == OP_MUL && ins[5:0] == FN_MUL) ? A_MUL :
             (ins[31:26] == OP_ADDI) ? A_ADDI :
             (ins[31:26] == OP_LW)   ? A_LW   :
             (ins[31:26] == OP_SW)   ? A_SW   : A_NOP;
   endfunction
   function automatic logic writes_reg(input alu_op_t op);
      return op != A_NOP && op != A_SW;
   endfunction
endpackage

// File: rtl/cpu_mul_seq.sv
// mul_seq: 32-iteration shift-add multiplier producing the low 32 bits of a*b
module mul_seq (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] product
);
   logic [31:0] mc, mp;
   logic [5:0]  cnt;
   logic        busy;
   // one partial-product step per clock; start restarts from scratch
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         product <= '0;
         mc      <= '0;
         mp      <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         product <= '0;
         mc      <= a;
         mp      <= b;
         cnt     <= 6'd32;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else if (busy) begin
         product <= product + (mp[0] ? mc : 32'd0);
         mc      <= mc << 1;
         mp      <= mp >> 1;
         cnt     <= cnt - 6'd1;
         busy    <= cnt != 6'd1;
         done    <= cnt == 6'd1;
      end
endmodule

// File: rtl/cpu.sv
// cpu: 5-stage MIPS-subset pipeline advanced by a divided tick, no hazard handling
module cpu import cpu_pkg::*; #(
   parameter int DIV     = DIV_DEFAULT,
   parameter int PC_STEP = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Prog_BUS_READ,
   input  logic [31:0] Data_BUS_READ,
   output logic [31:0] ADDR_Prog,
   output logic        CS_P,
   output logic [31:0] ADDR,
   output logic [31:0] Data_BUS_WRITE,
   output logic        CS,
   output logic        WR_RD
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt;
   logic          tick, tick_q, mul_start, mul_done, mem_acc;
   logic [31:0]   pc, if_id, mul_product, writeBack;
   logic [31:0]   rf [32];
   id_ex_t        id_ex, id_ex_d;
   ex_mem_t       ex_mem, ex_mem_d;
   mem_wb_t       mem_wb, mem_wb_d;
   assign tick      = cnt == CW'(DIV - 1);
   assign mul_start = tick_q && id_ex.op == A_MUL;
   assign writeBack = mem_wb.we ? mem_wb.val : '0;
   assign mem_acc   = ex_mem.op == A_LW || ex_mem.op == A_SW;
   assign ADDR_Prog      = pc;
   assign CS_P           = RST;
   assign CS             = mem_acc;
   assign WR_RD          = ex_mem.op == A_SW;
   assign ADDR           = mem_acc ? ex_mem.res : '0;
   assign Data_BUS_WRITE = ex_mem.op == A_SW ? ex_mem.store : '0;
   mul_seq u_mul (
      .CLK     (CLK),
      .RST     (RST),
      .start   (mul_start),
      .a       (id_ex.a),
      .b       (id_ex.b),
      .done    (mul_done),
      .product (mul_product)
   );
   // tick divider; tick_q marks the first clock of each tick period to launch MUL
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         cnt    <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt    <= tick ? '0 : cnt + 1'b1;
         tick_q <= tick;
      end
   // ID: decode and register reads; rf write lands on the same tick so old values are seen
   always_comb begin
      id_ex_d      = '0;
      id_ex_d.op   = decode(if_id);
      id_ex_d.dest = (id_ex_d.op == A_ADDI || id_ex_d.op == A_LW) ? if_id[20:16] : if_id[15:11];
      id_ex_d.we   = writes_reg(id_ex_d.op) && id_ex_d.dest != 5'd0;
      id_ex_d.a    = rf[if_id[25:21]];
      id_ex_d.b    = rf[if_id[20:16]];
      id_ex_d.imm  = {{16{if_id[15]}}, if_id[15:0]};
   end
   // EX: ALU result, address for LW/SW, or the finished multiplier product
   always_comb begin
      ex_mem_d       = '0;
      ex_mem_d.op    = id_ex.op;
      ex_mem_d.we    = id_ex.we;
      ex_mem_d.dest  = id_ex.dest;
      ex_mem_d.store = id_ex.b;
      ex_mem_d.res   = id_ex.op == A_ADD ? id_ex.a + id_ex.b :
                       id_ex.op == A_SUB ? id_ex.a - id_ex.b :
                       id_ex.op == A_AND ? id_ex.a & id_ex.b :
                       id_ex.op == A_OR  ? id_ex.a | id_ex.b :
                       id_ex.op == A_SLT ? {31'd0, $signed(id_ex.a) < $signed(id_ex.b)} :
                       id_ex.op == A_MUL ? (mul_done ? mul_product : '0) :
                       id_ex.a + id_ex.imm;
   end
   // MEM: loads take the bus data, everything else forwards the EX result
   always_comb begin
      mem_wb_d      = '0;
      mem_wb_d.we   = ex_mem.we;
      mem_wb_d.dest = ex_mem.dest;
      mem_wb_d.val  = ex_mem.op == A_LW ? Data_BUS_READ : ex_mem.res;
   end
   // PC and stage registers advance together on tick
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         pc     <= '0;
         if_id  <= NOP_WORD;
         id_ex  <= '0;
         ex_mem <= '0;
         mem_wb <= '0;
      end else if (tick) begin
         pc     <= pc + 32'(PC_STEP);
         if_id  <= Prog_BUS_READ;
         id_ex  <= id_ex_d;
         ex_mem <= ex_mem_d;
         mem_wb <= mem_wb_d;
      end
   // WB: register file write port; writes to $0 are already masked out in ID
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (tick && mem_wb.we) begin
         rf[mem_wb.dest] <= writeBack;
      end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program run with an ISA-level scoreboard checking bus, writeBack and registers
module tb_cpu;
   logic        CLK = 1'b0, RST = 1'b0;
   logic [31:0] Prog_BUS_READ, Data_BUS_READ, ADDR_Prog, ADDR, Data_BUS_WRITE;
   logic        CS_P, CS, WR_RD;
   logic [31:0] prog [64];
   logic [31:0] mr [32];
   int          total = 0, bad = 0;
   localparam logic [31:0] LOAD_VAL = 32'h0000_1234;
   localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;
   typedef struct packed {
      logic        we;
      logic [4:0]  dest;
      logic [31:0] val;
      logic        cs;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        is_lw;
   } exp_t;
   exp_t memq[$], wbq[$], rfq[$];

   cpu dut (
      .CLK(CLK), .RST(RST), .Prog_BUS_READ(Prog_BUS_READ), .Data_BUS_READ(Data_BUS_READ),
      .ADDR_Prog(ADDR_Prog), .CS_P(CS_P), .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE),
      .CS(CS), .WR_RD(WR_RD)
   );

   always #5 CLK = ~CLK;
   assign Prog_BUS_READ = prog[ADDR_Prog[7:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins);
      exp_t        e;
      logic [31:0] x, y, imm, r;
      logic        w;
      logic [4:0]  d;
      e   = '0;
      x   = mr[ins[25:21]];
      y   = mr[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      r   = '0;
      w   = 1'b0;
      d   = ins[15:11];
      case (ins[31:26])
         6'h00: begin
            w = 1'b1;
            case (ins[5:0])
               6'h20: r = x + y;
               6'h22: r = x - y;
               6'h24: r = x & y;
               6'h25: r = x | y;
               6'h2A: r = {31'd0, $signed(x) < $signed(y)};
               default: w = 1'b0;
            endcase
         end
         6'h1C: begin w = ins[5:0] == 6'h02; r = x * y; end
         6'h08: begin w = 1'b1; d = ins[20:16]; r = x + imm; end
         6'h23: begin w = 1'b1; d = ins[20:16]; r = LOAD_VAL; e.cs = 1'b1; e.addr = x + imm; e.is_lw = 1'b1; end
         6'h2B: begin e.cs = 1'b1; e.wr = 1'b1; e.addr = x + imm; e.wdata = y; end
         default: w = 1'b0;
      endcase
      if (w && d != 5'd0) begin
         mr[d]  = r;
         e.we   = 1'b1;
         e.dest = d;
         e.val  = r;
      end
      return e;
   endfunction

   task automatic step(input int n);
      exp_t e;
      memq.push_back(model(prog[n - 1]));
      wbq.push_back(memq[$]);
      rfq.push_back(memq[$]);
      if (n >= 3) begin
         e = memq.pop_front();
         chk($sformatf("cs@%0d", n), {31'd0, CS}, {31'd0, e.cs});
         chk($sformatf("wr_rd@%0d", n), {31'd0, WR_RD}, {31'd0, e.wr});
         chk($sformatf("addr@%0d", n), ADDR, e.addr);
         chk($sformatf("wdata@%0d", n), Data_BUS_WRITE, e.wdata);
         Data_BUS_READ = e.is_lw ? e.val : JUNK;
      end
      if (n >= 4) begin
         e = wbq.pop_front();
         chk($sformatf("writeBack@%0d", n), dut.writeBack, e.we ? e.val : 32'd0);
      end
      if (n >= 5) begin
         e = rfq.pop_front();
         if (e.we) chk($sformatf("rf%0d@%0d", e.dest, n), dut.rf[e.dest], e.val);
         chk($sformatf("r0@%0d", n), dut.rf[0], 32'd0);
      end
   endtask

   initial begin
      Data_BUS_READ = JUNK;
      for (int i = 0; i < 64; i++) prog[i] = 32'h0;
      for (int i = 0; i < 32; i++) mr[i] = 32'h0;
      prog[0]  = 32'h2001_0005;
      prog[5]  = 32'h2001_0007;
      prog[6]  = 32'h2002_0006;
      prog[10] = 32'h7022_1802;
      prog[11] = 32'h2001_FFFD;
      prog[15] = 32'h7022_3002;
      prog[16] = 32'hAC03_0008;
      prog[17] = 32'h8C04_0008;
      prog[18] = 32'h0022_3820;
      prog[19] = 32'h0022_4022;
      prog[20] = 32'h0022_4824;
      prog[21] = 32'h0022_5025;
      prog[22] = 32'h0022_582A;
      prog[23] = 32'h0041_602A;
      prog[24] = 32'h2000_0009;
      prog[25] = 32'hFC21_0000;
      prog[26] = 32'h0022_6821;
      prog[27] = 32'h200D_8000;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_addr_prog", ADDR_Prog, 32'd0);
      chk("rst_cs", {31'd0, CS}, 32'd0);
      chk("rst_cs_p", {31'd0, CS_P}, 32'd0);
      chk("rst_wr_rd", {31'd0, WR_RD}, 32'd0);
      chk("rst_wb", dut.writeBack, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("cs_p_run", {31'd0, CS_P}, 32'd1);
      repeat (33) @(posedge CLK);
      #1;
      chk("pc_before_tick", ADDR_Prog, 32'd0);
      @(posedge CLK);
      #1;
      chk("pc_first_tick", ADDR_Prog, 32'd4);
      step(1);
      for (int n = 2; n <= 34; n++) begin
         repeat (34) @(posedge CLK);
         #1;
         chk($sformatf("pc@%0d", n), ADDR_Prog, 32'(n * 4));
         step(n);
      end
      chk("r1_final", dut.rf[1], 32'hFFFF_FFFD);
      chk("r3_final", dut.rf[3], 32'd42);
      chk("r6_final", dut.rf[6], 32'hFFFF_FFEE);
      chk("r4_final", dut.rf[4], LOAD_VAL);
      chk("r13_final", dut.rf[13], 32'hFFFF_8000);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 64; i++) prog[i] = 32'h0;
      prog[0] = 32'h2001_0007;
      prog[1] = 32'h2002_0006;
      prog[5] = 32'h7022_2802;
      #1;
      chk("rst2_r3", dut.rf[3], 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (34 * 7 + 10) @(posedge CLK);
      #1;
      chk("mul_busy", {31'd0, dut.u_mul.busy}, 32'd1);
      chk("r1_before_abort", dut.rf[1], 32'd7);
      RST = 1'b0;
      #1;
      chk("abort_busy", {31'd0, dut.u_mul.busy}, 32'd0);
      chk("abort_pc", ADDR_Prog, 32'd0);
      chk("abort_r1", dut.rf[1], 32'd0);
      chk("abort_wb", dut.writeBack, 32'd0);
      chk("abort_cs_p", {31'd0, CS_P}, 32'd0);
      chk("abort_cs", {31'd0, CS}, 32'd0);
      for (int i = 0; i < 64; i++) prog[i] = 32'h0;
      @(negedge CLK);
      RST = 1'b1;
      repeat (33) @(posedge CLK);
      #1;
      chk("pc2_before_tick", ADDR_Prog, 32'd0);
      @(posedge CLK);
      #1;
      chk("pc2_first_tick", ADDR_Prog, 32'd4);
      for (int n = 2; n <= 8; n++) begin
         repeat (34) @(posedge CLK);
         #1;
         chk($sformatf("post_abort_wb@%0d", n), dut.writeBack, 32'd0);
         chk($sformatf("post_abort_r5@%0d", n), dut.rf[5], 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter DIV, default 34, number of CLK cycles per system tick (pipeline advance).
REQ-002 Parameter PC_STEP, default 4, byte increment of the program counter per fetch.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 Prog_BUS_READ  input  32  instruction word at ADDR_Prog.
REQ-006 Data_BUS_READ  input  32  data word at ADDR, valid whenever CS=1 and WR_RD=0.
REQ-007 ADDR_Prog  output  32  byte address of the instruction fetch (the PC).
REQ-008 CS_P  output  1  program memory select.
REQ-009 ADDR  output  32  data memory byte address.
REQ-010 Data_BUS_WRITE  output  32  store data.
REQ-011 CS  output  1  data memory select.
REQ-012 WR_RD  output  1  1 = write, 0 = read.

Function
REQ-013 A free-running counter 0..DIV-1 on CLK SHALL generate a one-CLK tick when it equals DIV-1; the CPU SHALL keep exactly one clock domain and use the tick only as an enable.
REQ-014 The CPU SHALL be a 5-stage pipeline (IF, ID, EX, MEM, WB) whose stage registers and PC update only on tick; there SHALL be no forwarding, hazard detection or stalls, so software inserts NOPs.
REQ-015 IF: ADDR_Prog = PC; on tick, IF/ID latches Prog_BUS_READ and PC += PC_STEP (32-bit wrap).
REQ-016 The all-zero word and any unsupported opcode/funct SHALL behave as NOP: no register or memory write.
REQ-017 Supported, standard MIPS encoding: R-type op 0 funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed); op 0x1C funct 0x02 MUL (rd = low 32 bits of rs*rt); op 0x08 ADDI (sign-extended imm, rt dest); op 0x23 LW; op 0x2B SW (addr = rs + sext(imm)).
REQ-018 Arithmetic SHALL be 32-bit two's complement with wrap, no overflow trap.
REQ-019 Register file: 32 x 32, two read ports in ID, one write port in WB on tick; register 0 reads 0, writes to it ignored; a WB write and an ID read of the same register in the same tick SHALL return the old value.
REQ-020 MUL: sequential shift-add multiplier clocked every CLK, started the CLK after an MUL enters EX, 32 iterations, result valid no later than CLK 33 of the tick period and latched into EX/MEM on the next tick.
REQ-021 MEM: for LW/SW, ADDR = EX address, CS = 1, WR_RD = 1 for SW (Data_BUS_WRITE = rt value) and 0 for LW; otherwise CS = 0, WR_RD = 0, ADDR and Data_BUS_WRITE = 0; LW latches Data_BUS_READ on the tick ending MEM.
REQ-022 Internal signal writeBack (32) SHALL carry the value being written to the register file in WB (0 when WB is not writing).
REQ-023 CS_P SHALL be 1 whenever RST is high.
REQ-024 Latency: an instruction fetched at tick k writes its register at tick k+4.

Reset
REQ-025 While RST=0: PC=0, tick counter=0, all pipeline registers = NOP, register file = 0, multiplier idle, CS=0, WR_RD=0, CS_P=0, ADDR=0, Data_BUS_WRITE=0, writeBack=0.
REQ-026 Reset asserted mid-operation (including mid-multiply) SHALL abort everything immediately; first tick occurs DIV CLK cycles after RST rises.

Structure
REQ-027 A shared package SHALL hold opcode/funct constants, NOP word, DIV default and the pipeline-register field typedefs.
REQ-028 The multiplier SHALL be one sub-module, mul_seq (start, a, b -> done, product).

Verification
REQ-029 RST low -> ADDR_Prog=0, CS=0, CS_P=0; release -> CS_P=1, ADDR_Prog=4 exactly 34 CLK later.
REQ-030 ADDI $1,$0,5 then 4 NOPs -> writeBack=5 on WB tick, $1=5.
REQ-031 $1=7, $2=6, MUL $3,$1,$2 -> writeBack=42; $1=-3 -> writeBack=0xFFFFFFEE.
REQ-032 SW $3,8($0) -> CS=1, WR_RD=1, ADDR=8, Data_BUS_WRITE=42; LW $4,8($0) with Data_BUS_READ=0x1234 -> CS=1, WR_RD=0, $4=0x1234.
REQ-033 ADDI $0,$0,9 and opcode 0x3F -> no register change, $0 reads 0.
REQ-034 RST low during MUL in EX -> all state cleared, no write of the partial product.
